// File: rtl/pipe_inst_decode.sv
// Instruction decode pipeline stage.
// Decodes one instruction per transfer into ALU opcode, operands, immediate and
// memory/write-back controls, held in a single output register with valid/ready
// handshaking, load-use stall detection and flush support.
module pipe_inst_decode #(
  parameter int INST_DW  = 32,
  parameter int PC_DW    = 32,
  parameter int REG_DW   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_DW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  input  logic [INST_DW-1:0]  inst_i,
  input  logic [PC_DW-1:0]    pc_i,
  output logic                id_ready_o,
  output logic                rs1_en_o,
  output logic                rs2_en_o,
  output logic [REG_AW-1:0]   rs1_addr_o,
  output logic [REG_AW-1:0]   rs2_addr_o,
  input  logic [REG_DW-1:0]   rs1_dout_i,
  input  logic [REG_DW-1:0]   rs2_dout_i,
  input  logic                flush_i,
  output logic                id_valid_o,
  input  logic                ex_ready_i,
  output logic [ALUOP_DW-1:0] alu_opcode_o,
  output logic [REG_DW-1:0]   operand_1_o,
  output logic [REG_DW-1:0]   operand_2_o,
  output logic [REG_DW-1:0]   imm_o,
  output logic [PC_DW-1:0]    pc_o,
  output logic                mem_ren_o,
  output logic                mem_wen_o,
  output logic                id_wb_en_o,
  output logic                id_wb_sel_o,
  output logic [REG_DW-1:0]   mem_din_o,
  output logic [REG_AW-1:0]   id_wb_addr_o,
  output logic                illegal_o
);

  localparam logic [ALUOP_DW-1:0] ALU_NOP   = ALUOP_DW'(0);
  localparam logic [ALUOP_DW-1:0] ALU_ADD   = ALUOP_DW'(1);
  localparam logic [ALUOP_DW-1:0] ALU_MUL   = ALUOP_DW'(2);
  localparam logic [ALUOP_DW-1:0] ALU_BNE   = ALUOP_DW'(3);
  localparam logic [ALUOP_DW-1:0] ALU_JAL   = ALUOP_DW'(4);
  localparam logic [ALUOP_DW-1:0] ALU_LUI   = ALUOP_DW'(5);
  localparam logic [ALUOP_DW-1:0] ALU_AUIPC = ALUOP_DW'(6);
  localparam logic [ALUOP_DW-1:0] ALU_AND   = ALUOP_DW'(7);
  localparam logic [ALUOP_DW-1:0] ALU_SLL   = ALUOP_DW'(8);
  localparam logic [ALUOP_DW-1:0] ALU_SLT   = ALUOP_DW'(9);
  localparam logic [ALUOP_DW-1:0] ALU_BLT   = ALUOP_DW'(10);
  localparam logic [ALUOP_DW-1:0] ALU_ADDI  = ALUOP_DW'(11);
  localparam logic [ALUOP_DW-1:0] ALU_SLTI  = ALUOP_DW'(12);
  localparam logic [ALUOP_DW-1:0] ALU_SW    = ALUOP_DW'(13);
  localparam logic [ALUOP_DW-1:0] ALU_LW    = ALUOP_DW'(14);
  localparam logic [ALUOP_DW-1:0] ALU_SUB   = ALUOP_DW'(15);

  logic [6:0]        opcodeField;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rdAddr;

  logic isRType, isIType, isLui, isAuipc, isJal, isBranch, isLoad, isStore;
  logic [ALUOP_DW-1:0] decAluOp;
  logic decIllegal, rs1Use, rs2Use, wbCapable;

  logic [REG_DW-1:0] immI, immS, immB, immU, immJ, pcExt;
  logic [REG_DW-1:0] decImm, decOp1, decOp2, decMemDin;
  logic              decWbEn;
  logic [REG_AW-1:0] decWbAddr;

  logic loadUseStall, inTransfer;

  logic                idValid_q, idValid_d;
  logic [ALUOP_DW-1:0] aluOpcode_q, aluOpcode_d;
  logic [REG_DW-1:0]   operand1_q, operand1_d;
  logic [REG_DW-1:0]   operand2_q, operand2_d;
  logic [REG_DW-1:0]   imm_q, imm_d;
  logic [PC_DW-1:0]    pc_q, pc_d;
  logic                memRen_q, memRen_d;
  logic                memWen_q, memWen_d;
  logic                wbEn_q, wbEn_d;
  logic                wbSel_q, wbSel_d;
  logic [REG_DW-1:0]   memDin_q, memDin_d;
  logic [REG_AW-1:0]   wbAddr_q, wbAddr_d;
  logic                illegal_q, illegal_d;

  assign opcodeField = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign funct7      = inst_i[31:25];
  assign rdAddr      = REG_AW'(inst_i[11:7]);

  // Classify the instruction and pick its ALU opcode; anything unmatched stays NOP.
  always_comb begin
    isRType  = 1'b0;
    isIType  = 1'b0;
    isLui    = 1'b0;
    isAuipc  = 1'b0;
    isJal    = 1'b0;
    isBranch = 1'b0;
    isLoad   = 1'b0;
    isStore  = 1'b0;
    decAluOp = ALU_NOP;
    case (opcodeField)
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          isRType = 1'b1; decAluOp = ALU_ADD;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          isRType = 1'b1; decAluOp = ALU_SUB;
        end else if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
          isRType = 1'b1; decAluOp = ALU_MUL;
        end else if (funct3 == 3'b111) begin
          isRType = 1'b1; decAluOp = ALU_AND;
        end else if (funct3 == 3'b001) begin
          isRType = 1'b1; decAluOp = ALU_SLL;
        end else if (funct3 == 3'b010) begin
          isRType = 1'b1; decAluOp = ALU_SLT;
        end
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          isIType = 1'b1; decAluOp = ALU_ADDI;
        end else if (funct3 == 3'b010) begin
          isIType = 1'b1; decAluOp = ALU_SLTI;
        end
      end
      7'b0110111: begin isLui = 1'b1; decAluOp = ALU_LUI; end
      7'b0010111: begin isAuipc = 1'b1; decAluOp = ALU_AUIPC; end
      7'b1101111: begin isJal = 1'b1; decAluOp = ALU_JAL; end
      7'b1100011: begin
        if (funct3 == 3'b001) begin
          isBranch = 1'b1; decAluOp = ALU_BNE;
        end else if (funct3 == 3'b100) begin
          isBranch = 1'b1; decAluOp = ALU_BLT;
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          isLoad = 1'b1; decAluOp = ALU_LW;
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          isStore = 1'b1; decAluOp = ALU_SW;
        end
      end
      default: ;
    endcase
  end

  assign decIllegal = !(isRType || isIType || isLui || isAuipc || isJal ||
                        isBranch || isLoad || isStore);
  assign rs1Use     = isRType || isIType || isBranch || isLoad || isStore;
  assign rs2Use     = isRType || isBranch || isStore;
  assign wbCapable  = isRType || isIType || isLui || isAuipc || isJal || isLoad;

  assign rs1_addr_o = REG_AW'(inst_i[19:15]);
  assign rs2_addr_o = REG_AW'(inst_i[24:20]);
  assign rs1_en_o   = if_valid_i && rs1Use;
  assign rs2_en_o   = if_valid_i && rs2Use;

  assign immI  = REG_DW'($signed(inst_i[31:20]));
  assign immS  = REG_DW'($signed({inst_i[31:25], inst_i[11:7]}));
  assign immB  = REG_DW'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign immU  = REG_DW'($signed({inst_i[31:12], 12'b0}));
  assign immJ  = REG_DW'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign pcExt = REG_DW'(pc_i);

  // Select immediate, operands, store data and write-back target for the decoded class.
  always_comb begin
    decImm    = '0;
    decOp1    = '0;
    decOp2    = '0;
    decMemDin = '0;
    if (isRType) begin
      decOp1 = rs1_dout_i;
      decOp2 = rs2_dout_i;
    end else if (isBranch) begin
      decImm = immB;
      decOp1 = rs1_dout_i;
      decOp2 = rs2_dout_i;
    end else if (isIType || isLoad) begin
      decImm = immI;
      decOp1 = rs1_dout_i;
      decOp2 = immI;
    end else if (isStore) begin
      decImm    = immS;
      decOp1    = rs1_dout_i;
      decOp2    = immS;
      decMemDin = rs2_dout_i;
    end else if (isLui) begin
      decImm = immU;
      decOp2 = immU;
    end else if (isAuipc) begin
      decImm = immU;
      decOp1 = pcExt;
      decOp2 = immU;
    end else if (isJal) begin
      decImm = immJ;
      decOp1 = pcExt;
      decOp2 = REG_DW'(4);
    end
  end

  assign decWbEn   = wbCapable && (rdAddr != '0);
  assign decWbAddr = wbCapable ? rdAddr : '0;

  // A load still in the output register blocks any consumer of its destination.
  assign loadUseStall = idValid_q && memRen_q && (wbAddr_q != '0) &&
                        ((rs1_en_o && (rs1_addr_o == wbAddr_q)) ||
                         (rs2_en_o && (rs2_addr_o == wbAddr_q)));

  assign id_ready_o = !rst && (flush_i || ((!idValid_q || ex_ready_i) && !loadUseStall));
  assign inTransfer = if_valid_i && id_ready_o;

  // Output register next state: flush drops everything, a transfer loads, a drain empties.
  always_comb begin
    idValid_d   = idValid_q;
    aluOpcode_d = aluOpcode_q;
    operand1_d  = operand1_q;
    operand2_d  = operand2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    memRen_d    = memRen_q;
    memWen_d    = memWen_q;
    wbEn_d      = wbEn_q;
    wbSel_d     = wbSel_q;
    memDin_d    = memDin_q;
    wbAddr_d    = wbAddr_q;
    illegal_d   = illegal_q;
    if (flush_i || (!inTransfer && idValid_q && ex_ready_i)) begin
      idValid_d = 1'b0;
      memRen_d  = 1'b0;
      memWen_d  = 1'b0;
      wbEn_d    = 1'b0;
      illegal_d = 1'b0;
    end else if (inTransfer) begin
      idValid_d   = 1'b1;
      aluOpcode_d = decAluOp;
      operand1_d  = decOp1;
      operand2_d  = decOp2;
      imm_d       = decImm;
      pc_d        = pc_i;
      memRen_d    = isLoad;
      memWen_d    = isStore;
      wbEn_d      = decWbEn;
      wbSel_d     = isLoad;
      memDin_d    = decMemDin;
      wbAddr_d    = decWbAddr;
      illegal_d   = decIllegal;
    end
  end

  // Output register with synchronous reset clearing every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      idValid_q   <= 1'b0;
      aluOpcode_q <= ALU_NOP;
      operand1_q  <= '0;
      operand2_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      memRen_q    <= 1'b0;
      memWen_q    <= 1'b0;
      wbEn_q      <= 1'b0;
      wbSel_q     <= 1'b0;
      memDin_q    <= '0;
      wbAddr_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      idValid_q   <= idValid_d;
      aluOpcode_q <= aluOpcode_d;
      operand1_q  <= operand1_d;
      operand2_q  <= operand2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      memRen_q    <= memRen_d;
      memWen_q    <= memWen_d;
      wbEn_q      <= wbEn_d;
      wbSel_q     <= wbSel_d;
      memDin_q    <= memDin_d;
      wbAddr_q    <= wbAddr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign id_valid_o   = idValid_q;
  assign alu_opcode_o = aluOpcode_q;
  assign operand_1_o  = operand1_q;
  assign operand_2_o  = operand2_q;
  assign imm_o        = imm_q;
  assign pc_o         = pc_q;
  assign mem_ren_o    = memRen_q;
  assign mem_wen_o    = memWen_q;
  assign id_wb_en_o   = wbEn_q;
  assign id_wb_sel_o  = wbSel_q;
  assign mem_din_o    = memDin_q;
  assign id_wb_addr_o = wbAddr_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_pipe_inst_decode.sv
// Directed self-checking bench for the instruction decode stage.
module tb_pipe_inst_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        id_ready_o;
  logic        rs1_en_o, rs2_en_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_dout_i, rs2_dout_i;
  logic        flush_i;
  logic        id_valid_o;
  logic        ex_ready_i;
  logic [4:0]  alu_opcode_o;
  logic [31:0] operand_1_o, operand_2_o, imm_o, pc_o;
  logic        mem_ren_o, mem_wen_o, id_wb_en_o, id_wb_sel_o;
  logic [31:0] mem_din_o;
  logic [4:0]  id_wb_addr_o;
  logic        illegal_o;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [31:0] inst, pc, rs1, rs2;
    logic [31:0] op, op1, op2, imm;
    logic [31:0] wbEn, wbSel, wbAddr, mRen, mWen, mDin, ill, rs1En, rs2En;
  } vec_t;

  vec_t vecs[12];

  pipe_inst_decode dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .inst_i(inst_i), .pc_i(pc_i),
    .id_ready_o(id_ready_o), .rs1_en_o(rs1_en_o), .rs2_en_o(rs2_en_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_dout_i(rs1_dout_i), .rs2_dout_i(rs2_dout_i), .flush_i(flush_i),
    .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i), .alu_opcode_o(alu_opcode_o),
    .operand_1_o(operand_1_o), .operand_2_o(operand_2_o), .imm_o(imm_o), .pc_o(pc_o),
    .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .id_wb_en_o(id_wb_en_o),
    .id_wb_sel_o(id_wb_sel_o), .mem_din_o(mem_din_o), .id_wb_addr_o(id_wb_addr_o),
    .illegal_o(illegal_o)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic exReady, input logic flush);
    if_valid_i = valid;
    inst_i     = inst;
    pc_i       = pc;
    rs1_dout_i = rs1;
    rs2_dout_i = rs2;
    ex_ready_i = exReady;
    flush_i    = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic runVector(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    applyStimulus(1'b1, v.inst, v.pc, v.rs1, v.rs2, 1'b1, 1'b0);
    #1;
    checkOutput({t, "_ready"}, 32'(id_ready_o), 32'd1);
    checkOutput({t, "_rs1En"}, 32'(rs1_en_o), v.rs1En);
    checkOutput({t, "_rs2En"}, 32'(rs2_en_o), v.rs2En);
    tick();
    checkOutput({t, "_valid"}, 32'(id_valid_o), 32'd1);
    checkOutput({t, "_opcode"}, 32'(alu_opcode_o), v.op);
    checkOutput({t, "_op1"}, operand_1_o, v.op1);
    checkOutput({t, "_op2"}, operand_2_o, v.op2);
    checkOutput({t, "_imm"}, imm_o, v.imm);
    checkOutput({t, "_pc"}, pc_o, v.pc);
    checkOutput({t, "_wbEn"}, 32'(id_wb_en_o), v.wbEn);
    checkOutput({t, "_wbSel"}, 32'(id_wb_sel_o), v.wbSel);
    checkOutput({t, "_wbAddr"}, 32'(id_wb_addr_o), v.wbAddr);
    checkOutput({t, "_memRen"}, 32'(mem_ren_o), v.mRen);
    checkOutput({t, "_memWen"}, 32'(mem_wen_o), v.mWen);
    checkOutput({t, "_memDin"}, mem_din_o, v.mDin);
    checkOutput({t, "_illegal"}, 32'(illegal_o), v.ill);
    idleCycle();
    checkOutput({t, "_drainValid"}, 32'(id_valid_o), 32'd0);
    checkOutput({t, "_drainCtl"}, {28'd0, mem_ren_o, mem_wen_o, id_wb_en_o, illegal_o}, 32'd0);
  endtask

  // Main directed sequence.
  initial begin
    vecs[0]  = '{32'h002081B3, 32'h40, 32'd5, 32'd7, 32'd1, 32'd5, 32'd7, 32'd0,
                 32'd1, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    vecs[1]  = '{32'h40208233, 32'h44, 32'd20, 32'd3, 32'd15, 32'd20, 32'd3, 32'd0,
                 32'd1, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    vecs[2]  = '{32'h022081B3, 32'h48, 32'd6, 32'd7, 32'd2, 32'd6, 32'd7, 32'd0,
                 32'd1, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    vecs[3]  = '{32'h0020A1B3, 32'h4C, 32'd3, 32'd9, 32'd9, 32'd3, 32'd9, 32'd0,
                 32'd1, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    vecs[4]  = '{32'hFE209CE3, 32'h50, 32'd9, 32'd10, 32'd3, 32'd9, 32'd10, 32'hFFFFFFF8,
                 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    vecs[5]  = '{32'h0020A623, 32'h54, 32'h1000, 32'hDEAD, 32'd13, 32'h1000, 32'd12, 32'd12,
                 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'hDEAD, 32'd0, 32'd1, 32'd1};
    vecs[6]  = '{32'hFFF08393, 32'h58, 32'd100, 32'd55, 32'd11, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'd1, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
    vecs[7]  = '{32'h12345437, 32'h5C, 32'd1, 32'd2, 32'd5, 32'd0, 32'h12345000, 32'h12345000,
                 32'd1, 32'd0, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[8]  = '{32'h00001497, 32'h200, 32'd1, 32'd2, 32'd6, 32'h200, 32'h1000, 32'h1000,
                 32'd1, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[9]  = '{32'h020000EF, 32'h100, 32'd1, 32'd2, 32'd4, 32'h100, 32'd4, 32'h20,
                 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[10] = '{32'hFFFFFFFF, 32'h60, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0,
                 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
    vecs[11] = '{32'h0000A283, 32'h64, 32'h300, 32'd2, 32'd14, 32'h300, 32'd0, 32'd0,
                 32'd1, 32'd1, 32'd5, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("rst_ready", 32'(id_ready_o), 32'd0);
    checkOutput("rst_valid", 32'(id_valid_o), 32'd0);
    checkOutput("rst_opcode", 32'(alu_opcode_o), 32'd0);
    checkOutput("rst_illegal", 32'(illegal_o), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_ready", 32'(id_ready_o), 32'd1);

    // Decode table
    foreach (vecs[i]) runVector(vecs[i], i);

    // Load-use stall: lw x5 then add x6,x5,x2
    applyStimulus(1'b1, 32'h0000A283, 32'h80, 32'h10, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("lu_lwValid", 32'(id_valid_o), 32'd1);
    applyStimulus(1'b1, 32'h00228333, 32'h84, 32'd11, 32'd22, 1'b1, 1'b0);
    #1;
    checkOutput("lu_stallReady", 32'(id_ready_o), 32'd0);
    tick();
    checkOutput("lu_bubbleValid", 32'(id_valid_o), 32'd0);
    checkOutput("lu_bubbleReady", 32'(id_ready_o), 32'd1);
    tick();
    checkOutput("lu_addValid", 32'(id_valid_o), 32'd1);
    checkOutput("lu_addOpcode", 32'(alu_opcode_o), 32'd1);
    checkOutput("lu_addWbAddr", 32'(id_wb_addr_o), 32'd6);
    checkOutput("lu_addOp1", operand_1_o, 32'd11);
    idleCycle();

    // lw x0 followed by add x6,x0,x2 does not stall
    applyStimulus(1'b1, 32'h0000A003, 32'h90, 32'h10, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("lw0_wbEn", 32'(id_wb_en_o), 32'd0);
    checkOutput("lw0_memRen", 32'(mem_ren_o), 32'd1);
    applyStimulus(1'b1, 32'h00200333, 32'h94, 32'd0, 32'd33, 1'b1, 1'b0);
    #1;
    checkOutput("lw0_noStallReady", 32'(id_ready_o), 32'd1);
    tick();
    checkOutput("lw0_addValid", 32'(id_valid_o), 32'd1);
    checkOutput("lw0_addPc", pc_o, 32'h94);
    checkOutput("lw0_addOp2", operand_2_o, 32'd33);
    idleCycle();

    // Backpressure: held SUB with ex_ready low for three cycles
    applyStimulus(1'b1, 32'h40208233, 32'hA0, 32'd20, 32'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hFFF08393, 32'hA4, 32'd100, 32'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp_ready%0d", c), 32'(id_ready_o), 32'd0);
      tick();
      checkOutput($sformatf("bp_valid%0d", c), 32'(id_valid_o), 32'd1);
      checkOutput($sformatf("bp_opcode%0d", c), 32'(alu_opcode_o), 32'd15);
      checkOutput($sformatf("bp_op1_%0d", c), operand_1_o, 32'd20);
      checkOutput($sformatf("bp_pc%0d", c), pc_o, 32'hA0);
    end
    ex_ready_i = 1'b1;
    #1;
    checkOutput("bp_relReady", 32'(id_ready_o), 32'd1);
    tick();
    checkOutput("bp_nextOpcode", 32'(alu_opcode_o), 32'd11);
    checkOutput("bp_nextPc", pc_o, 32'hA4);
    idleCycle();

    // Flush with a held JAL and an incoming instruction
    applyStimulus(1'b1, 32'h020000EF, 32'h100, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("fl_jalValid", 32'(id_valid_o), 32'd1);
    applyStimulus(1'b1, 32'h002081B3, 32'h104, 32'd5, 32'd7, 1'b0, 1'b1);
    #1;
    checkOutput("fl_ready", 32'(id_ready_o), 32'd1);
    tick();
    checkOutput("fl_valid", 32'(id_valid_o), 32'd0);
    checkOutput("fl_wbEn", 32'(id_wb_en_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("fl_dropped", 32'(id_valid_o), 32'd0);

    // Reset asserted during a load-use stall
    applyStimulus(1'b1, 32'h0000A283, 32'hC0, 32'h10, 32'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00228333, 32'hC4, 32'd4, 32'd8, 1'b1, 1'b0);
    #1;
    checkOutput("rs_stallReady", 32'(id_ready_o), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("rs_valid", 32'(id_valid_o), 32'd0);
    checkOutput("rs_opcode", 32'(alu_opcode_o), 32'd0);
    checkOutput("rs_data", operand_1_o | operand_2_o | imm_o | pc_o | mem_din_o, 32'd0);
    checkOutput("rs_ctl", {26'd0, mem_ren_o, mem_wen_o, id_wb_en_o, id_wb_sel_o, illegal_o, |id_wb_addr_o}, 32'd0);
    checkOutput("rs_ready", 32'(id_ready_o), 32'd0);
    tick();
    checkOutput("rs_ready2", 32'(id_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rs_relReady", 32'(id_ready_o), 32'd1);
    tick();
    checkOutput("rs_addValid", 32'(id_valid_o), 32'd1);
    checkOutput("rs_addPc", pc_o, 32'hC4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
